// File: rtl/div_32bit_seq.sv
// div_32bit_seq: radix-2 restoring divider, signed or unsigned,
// one quotient bit per cycle with RISC-V M-extension corner results.
module div_32bit_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        is_signed,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] quot,
   output logic [31:0] rem
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t      state;
   state_t      state_nx;

   logic [4:0]  cnt;
   logic [31:0] prem;
   logic [31:0] dvd;
   logic [31:0] dvs;
   logic        neg_q;
   logic        neg_r;

   logic        accept;
   logic        div0;
   logic        ovf;
   logic        last;
   logic [31:0] abs_a;
   logic [31:0] abs_b;

   logic [32:0] shl;
   logic [32:0] diff;
   logic        qbit;
   logic [31:0] prem_nx;
   logic [31:0] dvd_nx;

   assign accept = in_valid & in_ready;
   assign div0   = (b == 32'd0);
   assign ovf    = is_signed & (a == 32'h8000_0000)
                 & (b == 32'hFFFF_FFFF);
   assign last   = (cnt == 5'd31);
   assign abs_a  = (is_signed & a[31]) ? -a : a;
   assign abs_b  = (is_signed & b[31]) ? -b : b;

   // dvd shifts the dividend out at the top and the quotient in at the bottom
   always_comb begin
      shl     = {prem, dvd[31]};
      diff    = shl - {1'b0, dvs};
      qbit    = ~diff[32];
      prem_nx = qbit ? diff[31:0] : shl[31:0];
      dvd_nx  = {dvd[30:0], qbit};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nx = (div0 | ovf) ? DONE : CALC;
            end
         end
         CALC: begin
            if (last) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt   <= 5'd0;
         prem  <= 32'd0;
         dvd   <= 32'd0;
         dvs   <= 32'd0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         quot  <= 32'd0;
         rem   <= 32'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  if (div0) begin
                     quot <= 32'hFFFF_FFFF;
                     rem  <= a;
                  end else if (ovf) begin
                     quot <= 32'h8000_0000;
                     rem  <= 32'd0;
                  end else begin
                     dvd   <= abs_a;
                     dvs   <= abs_b;
                     prem  <= 32'd0;
                     cnt   <= 5'd0;
                     neg_q <= is_signed & (a[31] ^ b[31]);
                     neg_r <= is_signed & a[31];
                  end
               end
            end
            CALC: begin
               prem <= prem_nx;
               dvd  <= dvd_nx;
               cnt  <= cnt + 5'd1;
               // final step result goes straight to the sign-fixed outputs
               if (last) begin
                  quot <= neg_q ? -dvd_nx : dvd_nx;
                  rem  <= neg_r ? -prem_nx : prem_nx;
               end
            end
            DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_32bit_seq.sv
// tb_div_32bit_seq: directed and reference-model checks
// for the sequential 32-bit divider.
module tb_div_32bit_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        is_signed = 1'b0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] quot;
   logic [31:0] rem;

   int nchk = 0;
   int nerr = 0;

   div_32bit_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quot      (quot),
      .rem       (rem)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void ref_div(input logic s,
                                   input logic [31:0] av,
                                   input logic [31:0] bv,
                                   output logic [31:0] q,
                                   output logic [31:0] r);
      int sa;
      int sb;
      sa = av;
      sb = bv;
      if (bv == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = av;
      end else if (s && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else if (s) begin
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = av / bv;
         r = av % bv;
      end
   endfunction

   task automatic run(input string tag, input logic s,
                      input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] eq, input logic [31:0] er);
      int lat;
      int elat;
      elat = (bv == 32'd0 ||
              (s && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF)) ? 1 : 33;
      @(negedge clk);
      check({tag, " ready"}, 32'(in_ready), 32'd1);
      is_signed = s;
      a         = av;
      b         = bv;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      a         = $urandom;
      b         = $urandom;
      is_signed = ~s;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 50);
      check({tag, " lat"}, 32'(lat), 32'(elat));
      check({tag, " quot"}, quot, eq);
      check({tag, " rem"}, rem, er);
      @(negedge clk);
      check({tag, " idle"}, {30'd0, out_valid, in_ready}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] eq;
      logic [31:0] er;
      logic [31:0] av;
      logic [31:0] bv;
      logic        s;
      logic [31:0] spec [5];
      int          w;

      spec[0] = 32'd0;
      spec[1] = 32'd1;
      spec[2] = 32'hFFFF_FFFF;
      spec[3] = 32'h8000_0000;
      spec[4] = 32'h7FFF_FFFF;

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst quot", quot, 32'd0);
      check("rst rem", rem, 32'd0);
      rst_n = 1'b1;

      run("u100/7", 0, 32'd100, 32'd7, 32'd14, 32'd2);
      run("s-7/2", 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      run("u-7/2", 0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1);
      run("s7/-2", 1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
      run("s5/0", 1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
      run("u5/0", 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
      run("s_ovf", 1, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h8000_0000, 32'd0);
      run("u_min/-1", 0, 32'h8000_0000, 32'hFFFF_FFFF,
          32'd0, 32'h8000_0000);
      run("s_min/2", 1, 32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0);
      run("u_max/1", 0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);

      // result held while the consumer stalls
      @(negedge clk);
      is_signed = 1'b0;
      a         = 32'd1000;
      b         = 32'd10;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!out_valid && w < 50);
      check("hold lat", 32'(w), 32'd33);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold valid", 32'(out_valid), 32'd1);
         check("hold quot", quot, 32'd100);
         check("hold rem", rem, 32'd0);
         check("hold in_ready", 32'(in_ready), 32'd0);
         in_valid  = i[0];
         a         = $urandom;
         b         = $urandom;
         is_signed = ~is_signed;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("hold release", {30'd0, out_valid, in_ready}, 32'd1);

      // reset aborts an in-flight division
      @(negedge clk);
      is_signed = 1'b0;
      a         = 32'd100;
      b         = 32'd7;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         check("calc in_ready", 32'(in_ready), 32'd0);
         a = $urandom;
         b = $urandom;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("abort out_valid", 32'(out_valid), 32'd0);
      check("abort in_ready", 32'(in_ready), 32'd1);
      check("abort quot", quot, 32'd0);
      check("abort rem", rem, 32'd0);
      run("u100/7 again", 0, 32'd100, 32'd7, 32'd14, 32'd2);

      for (int i = 0; i < 200; i++) begin
         av = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 4)]
                                          : $urandom;
         bv = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 4)]
                                          : $urandom;
         if ($urandom_range(0, 2) == 0) bv = bv >> $urandom_range(1, 31);
         s = 1'($urandom_range(0, 1));
         ref_div(s, av, bv, eq, er);
         run("rand", s, av, bv, eq, er);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
